dmem_port_arbiter: RTL and testbench

//  Shares the single data-memory port (dmem) between two requesters: port 0 = core load/store

---
 rtl/dmem_arb_pkg.sv | 36 +++
 rtl/dmem_port_arbiter_hold_counter.sv | 36 +++
 rtl/dmem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// Port 0 is the core LSU, port 1 the debug/loader master.
package dmem_arb_pkg;

    localparam int PORT_CORE  = 0;
    localparam int PORT_DBG   = 1;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    typedef struct packed {
        logic                    we;
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W-1:0]   wdata;
        logic [ARB_DATA_W/8-1:0] be;
    } dmem_req_t;

    // Tie goes to the port that did not win last time.
    function automatic logic [1:0] rr_pick(
        input logic [1:0] req,
        input logic       last
    );
        logic [1:0] g;
        g = req;
        if (&req) begin
            g = last ? 2'b01 : 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_hold_counter.sv
// Saturating grant counter bounding how long a locking owner
// may keep the dmem port while the other side waits.
module arb_hold_counter #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt = (inc && (cnt_q != CMAX))
                   ? cnt_q + CW'(1)
                   : cnt_q;

    // Flag reflects the count once this cycle's increment lands.
    assign sat = (cnt_nxt == CMAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: round-robin between LSU and debug loader,
// with lock ownership bounded by a hold counter.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 req_i,
    input  logic [1:0]                 lock_i,
    input  logic [1:0]                 we_i,
    input  logic [1:0][ADDR_W-1:0]     addr_i,
    input  logic [1:0][DATA_W-1:0]     wdata_i,
    input  logic [1:0][DATA_W/8-1:0]   be_i,
    output logic [1:0]                 gnt_o,
    output logic [1:0]                 rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       mem_en_o,
    output logic                       mem_we_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic [DATA_W/8-1:0]        mem_be_o,
    input  logic [DATA_W-1:0]          mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;

    owner_e     state_q;
    owner_e     state_d;
    logic       last_q;
    logic [1:0] gnt;
    logic       any;
    logic       win;
    logic       cur;
    logic       in_own;
    logic       own_nxt;
    logic       hold_inc;
    logic       hold_sat;
    logic [1:0] rvalid_q;
    dmem_req_t  port_req [2];
    dmem_req_t  sel;

    always_comb begin
        gnt = 2'b00;
        unique case (state_q)
            OWN0:    gnt = {1'b0, req_i[PORT_CORE]};
            OWN1:    gnt = {req_i[PORT_DBG], 1'b0};
            default: gnt = rr_pick(req_i, last_q);
        endcase
        if (!reset_n) begin
            gnt = 2'b00;
        end
    end

    assign any    = |gnt;
    assign win    = gnt[PORT_DBG];
    assign in_own = (state_q != IDLE);

    // Port whose lock decides ownership: current owner, else the winner.
    assign cur = (state_q == OWN1) ? 1'b1
               : (state_q == OWN0) ? 1'b0
               : win;

    assign hold_inc = any & (in_own | lock_i[win]);

    assign own_nxt = (in_own | any)
                   & lock_i[cur]
                   & ~(hold_sat & req_i[~cur]);

    always_comb begin
        state_d = IDLE;
        if (own_nxt) begin
            state_d = cur ? OWN1 : OWN0;
        end
    end

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hold_inc),
        .clr     (~own_nxt),
        .sat     (hold_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            rvalid_q <= gnt & ~we_i;
            if (any) begin
                last_q <= win;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            port_req[p].we    = we_i[p];
            port_req[p].addr  = ARB_ADDR_W'(addr_i[p]);
            port_req[p].wdata = ARB_DATA_W'(wdata_i[p]);
            port_req[p].be    = (ARB_DATA_W/8)'(be_i[p]);
        end
    end

    always_comb begin
        sel = '0;
        unique case (1'b1)
            gnt[PORT_CORE]: sel = port_req[PORT_CORE];
            gnt[PORT_DBG]:  sel = port_req[PORT_DBG];
            default:        sel = '0;
        endcase
    end

    assign gnt_o       = gnt;
    assign mem_en_o    = any;
    assign mem_we_o    = sel.we;
    assign mem_addr_o  = ADDR_W'(sel.addr);
    assign mem_wdata_o = DATA_W'(sel.wdata);
    assign mem_be_o    = BE_W'(sel.be);
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = mem_rdata_i;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: queue-driven requesters, transaction
// model of the arbitration rules, and directed literal checks.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MH = 16;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [1:0]            req_i;
    logic [1:0]            lock_i;
    logic [1:0]            we_i;
    logic [1:0][AW-1:0]    addr_i;
    logic [1:0][DW-1:0]    wdata_i;
    logic [1:0][BW-1:0]    be_i;
    logic [1:0]            gnt_o;
    logic [1:0]            rvalid_o;
    logic [DW-1:0]         rdata_o;
    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [AW-1:0]         mem_addr_o;
    logic [DW-1:0]         mem_wdata_o;
    logic [BW-1:0]         mem_be_o;
    logic [DW-1:0]         mem_rdata_i = '0;

    dmem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic          lock;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } op_t;

    op_t q0[$];
    op_t q1[$];

    logic [31:0] envmem [logic [31:0]];
    logic [31:0] mdlmem [logic [31:0]];

    int          passed = 0;
    int          total  = 0;
    bit          chk_on = 1'b0;
    int          cyc    = 0;

    // model state: owner -1 = nobody
    int          m_own  = -1;
    int          m_last = 1;
    int          m_hold = 0;
    logic [1:0]  m_rv   = 2'b00;
    logic [31:0] m_rdata = '0;

    int          g_cyc[$];
    logic [1:0]  g_val[$];
    logic [31:0] g_addr[$];
    int          r_cyc[$];
    logic [1:0]  r_val[$];
    logic [31:0] r_dat[$];

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdlmem.exists(a) ? mdlmem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return envmem.exists(a) ? envmem[a] : 32'h0;
    endfunction

    task automatic drive();
        op_t o0;
        op_t o1;
        o0 = '0;
        o1 = '0;
        if (q0.size() != 0) o0 = q0[0];
        if (q1.size() != 0) o1 = q1[0];
        req_i      = {q1.size() != 0, q0.size() != 0};
        we_i       = {o1.we, o0.we};
        lock_i     = {o1.lock, o0.lock};
        addr_i[0]  = o0.addr;
        addr_i[1]  = o1.addr;
        wdata_i[0] = o0.wdata;
        wdata_i[1] = o1.wdata;
        be_i[0]    = o0.be;
        be_i[1]    = o1.be;
    endtask

    task automatic push(input int port, input bit we, input bit lock,
                        input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o = {we, lock, a, d, 4'hF};
        if (port == 0) q0.push_back(o);
        else q1.push_back(o);
    endtask

    // Who should be granted now, from the arbitration rules.
    function automatic logic [1:0] mdl_gnt();
        if (!reset_n) return 2'b00;
        if (m_own >= 0) return req_i[m_own] ? 2'(1 << m_own) : 2'b00;
        if (req_i == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
        return req_i;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [1:0] g;
        int p;
        int o;
        if (!reset_n) begin
            m_own  = -1;
            m_last = 1;
            m_hold = 0;
            m_rv   = 2'b00;
            q0.delete();
            q1.delete();
            drive();
        end else begin
            g = mdl_gnt();
            p = g[1] ? 1 : 0;
            m_rv = 2'b00;
            if (g != 2'b00) begin
                if (!we_i[p]) begin
                    m_rv[p] = 1'b1;
                    m_rdata = mdl_rd(addr_i[p]);
                end else begin
                    mdlmem[addr_i[p]] = merge(mdl_rd(addr_i[p]),
                                              wdata_i[p], be_i[p]);
                end
                if (p == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
            if (m_own < 0) begin
                if (g != 2'b00) begin
                    m_last = p;
                    if (lock_i[p] && !(MH == 1 && req_i[1-p])) begin
                        m_own  = p;
                        m_hold = 1;
                    end
                end
            end else begin
                o = m_own;
                if (g != 2'b00 && m_hold < MH) m_hold++;
                if (!lock_i[o] || (m_hold == MH && req_i[1-o])) begin
                    m_own  = -1;
                    m_hold = 0;
                end
            end
            cyc++;
            #1 drive();
        end
    end

    always @(posedge clk) begin
        if (reset_n && mem_en_o) begin
            if (mem_we_o)
                envmem[mem_addr_o] = merge(env_rd(mem_addr_o),
                                           mem_wdata_o, mem_be_o);
            else
                mem_rdata_i <= env_rd(mem_addr_o);
        end
    end

    always @(negedge clk) begin
        logic [1:0] eg;
        int p;
        if (chk_on) begin
            eg = mdl_gnt();
            p = eg[1] ? 1 : 0;
            check("gnt", gnt_o, eg);
            check("mem_en", mem_en_o, |eg);
            if (eg != 2'b00) begin
                check("mem_we", mem_we_o, we_i[p]);
                check("mem_addr", mem_addr_o, addr_i[p]);
                check("mem_wdata", mem_wdata_o, wdata_i[p]);
                check("mem_be", mem_be_o, be_i[p]);
            end else begin
                check("mem_addr_idle", mem_addr_o, 32'h0);
                check("mem_we_idle", mem_we_o, 1'b0);
            end
            check("rvalid", rvalid_o, m_rv);
            if (m_rv != 2'b00) check("rdata", rdata_o, m_rdata);
            if (gnt_o != 2'b00) begin
                g_cyc.push_back(cyc);
                g_val.push_back(gnt_o);
                g_addr.push_back(mem_addr_o);
            end
            if (rvalid_o != 2'b00) begin
                r_cyc.push_back(cyc);
                r_val.push_back(rvalid_o);
                r_dat.push_back(rdata_o);
            end
        end
    end

    task automatic clear_logs();
        g_cyc.delete();
        g_val.delete();
        g_addr.delete();
        r_cyc.delete();
        r_val.delete();
        r_dat.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_own >= 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            $display("FAIL %s_timeout: still busy after %0d cycles", tag, n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n1;
        drive();
        envmem[32'h10] = 32'hAAAA0010;
        mdlmem[32'h10] = 32'hAAAA0010;
        envmem[32'h20] = 32'hBBBB0020;
        mdlmem[32'h20] = 32'hBBBB0020;
        envmem[32'h1C] = 32'hDEAD0000;
        mdlmem[32'h1C] = 32'hDEAD0000;
        chk_on = 1'b1;

        // reset held with both ports requesting
        repeat (2) @(negedge clk);
        req_i = 2'b11;
        #2;
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_mem_en", mem_en_o, 1'b0);
        check("rst_rvalid", rvalid_o, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        drive();
        @(negedge clk);

        // tie from idle
        clear_logs();
        push(0, 1'b0, 1'b0, 32'h10, 32'h0);
        push(1, 1'b0, 1'b0, 32'h20, 32'h0);
        wait_idle("tie", 20);
        check("tie_ngrants", g_val.size(), 2);
        check("tie_g0", g_val[0], 2'b01);
        check("tie_a0", g_addr[0], 32'h10);
        check("tie_g1", g_val[1], 2'b10);
        check("tie_a1", g_addr[1], 32'h20);
        check("tie_rv0", r_val[0], 2'b01);
        check("tie_rd0", r_dat[0], 32'hAAAA0010);
        check("tie_rv1", r_val[1], 2'b10);
        check("tie_rd1", r_dat[1], 32'hBBBB0020);

        // store then load of the same word
        clear_logs();
        push(1, 1'b1, 1'b0, 32'h1C, 32'h7);
        @(negedge clk);
        push(0, 1'b0, 1'b0, 32'h1C, 32'h0);
        wait_idle("stld", 20);
        check("stld_g0", g_val[0], 2'b10);
        check("stld_g1", g_val[1], 2'b01);
        check("stld_nrv", r_val.size(), 1);
        check("stld_rv", r_val[0], 2'b01);
        check("stld_rd", r_dat[0], 32'h7);
        check("stld_lat", r_cyc[0] - g_cyc[1], 1);

        // four-beat lock while port 0 waits
        clear_logs();
        push(1, 1'b1, 1'b1, 32'h40, 32'h1);
        push(1, 1'b1, 1'b1, 32'h44, 32'h2);
        push(1, 1'b1, 1'b1, 32'h48, 32'h3);
        push(1, 1'b1, 1'b0, 32'h4C, 32'h4);
        @(negedge clk);
        push(0, 1'b0, 1'b0, 32'h10, 32'h0);
        wait_idle("lock", 30);
        for (int i = 0; i < 4; i++) check("lock_beat", g_val[i], 2'b10);
        check("lock_then0", g_val[4], 2'b01);
        check("lock_span", g_cyc[4] - g_cyc[0], 4);

        // forced release after MH grants
        clear_logs();
        for (int i = 0; i < 20; i++)
            push(1, 1'b1, 1'b1, 32'h100 + 4*i, 32'(i));
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            push(0, 1'b0, 1'b0, 32'h20, 32'h0);
        wait_idle("force", 200);
        n1 = 0;
        while (n1 < g_val.size() && g_val[n1] == 2'b10) n1++;
        check("force_count", n1, 16);
        check("force_span", g_cyc[15] - g_cyc[0], 15);
        check("force_g16", g_val[16], 2'b01);
        check("force_g17", g_val[17], 2'b10);

        // reset while locked, right after a granted load
        clear_logs();
        push(1, 1'b0, 1'b1, 32'h20, 32'h0);
        push(1, 1'b0, 1'b1, 32'h10, 32'h0);
        push(1, 1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_gnt", gnt_o, 2'b10);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_rv", rvalid_o, 2'b00);
        check("mid_rst_gnt", gnt_o, 2'b00);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("mid_post_rv", rvalid_o, 2'b00);
        clear_logs();
        push(0, 1'b0, 1'b0, 32'h10, 32'h0);
        push(1, 1'b0, 1'b0, 32'h20, 32'h0);
        wait_idle("post", 20);
        check("post_g0", g_val[0], 2'b01);
        check("post_g1", g_val[1], 2'b10);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
